// File: rtl/slice_unloader_if.sv
// Handshake bundle for slice_unloader: slice input (valid/ready/data) and
// serial bit output (valid/ready/bit). The master drives slices in and
// accepts bits out. The slave is the unloader itself.
interface slice_unloader_if #(
   parameter int WORD_LENGTH = 25
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WORD_LENGTH-1:0] in_data;
   logic                   out_bit;
   logic                   out_valid;
   logic                   out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_bit, out_valid
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_bit, out_valid
   );
endinterface

// File: rtl/slice_unloader.sv
// slice_unloader: reader side of the 25-bit slice load path. Accepts one
// slice per page and drains it LSB first as a serial bit stream, walking
// NUM_PAGE pages per frame. Optional macro SLICE_PARITY_EN appends one even
// parity bit after each slice (26 bits per page instead of 25).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; busy low
// S_LOAD  | in_ready high, waiting for a slice on the input handshake
// S_SHIFT | out_valid high, sending bits LSB first (plus parity bit)
// S_DONE  | done pulse for one cycle, then back to S_IDLE
module slice_unloader #(
   parameter int WORD_LENGTH = 25,
   parameter int NUM_PAGE    = 64,
   parameter int PAGE_BITS   = 6,
   parameter int BIT_BITS    = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   slice_unloader_if.slave      bus,
   output logic [PAGE_BITS-1:0] page_idx,
   output logic                 busy,
   output logic                 done
);

`ifdef SLICE_PARITY_EN
   // Bit index WORD_LENGTH is the parity bit that follows the slice.
   localparam logic [BIT_BITS-1:0] LAST_BIT = BIT_BITS'(WORD_LENGTH);
`else
   localparam logic [BIT_BITS-1:0] LAST_BIT = BIT_BITS'(WORD_LENGTH - 1);
`endif
   localparam logic [PAGE_BITS-1:0] LAST_PAGE = PAGE_BITS'(NUM_PAGE - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t                 state;
   logic [WORD_LENGTH-1:0] shift_reg;
   logic [BIT_BITS-1:0]    bit_cnt;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic                   fill_bit;

   // out_bit is taken straight from the shift register LSB, so it is a flop
   // output and stays put while the downstream stalls.
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_bit   = shift_reg[0];

`ifdef SLICE_PARITY_EN
   logic parity;

   // Capture even parity of the slice at load. It fills in from the top
   // while shifting, so after the 25th shift it sits in shift_reg[0].
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         parity <= 1'b0;
      else if (state == S_LOAD && bus.in_valid && in_ready_q)
         parity <= ^bus.in_data;
   end

   assign fill_bit = parity;
`else
   assign fill_bit = 1'b0;
`endif

   // Main sequencer: frame/page/bit walk with registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         page_idx    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_LOAD;
                  busy       <= 1'b1;
                  in_ready_q <= 1'b1;
                  page_idx   <= '0;
               end
            end
            S_LOAD: begin
               if (bus.in_valid && in_ready_q) begin
                  shift_reg   <= bus.in_data;
                  bit_cnt     <= '0;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bus.out_ready) begin
                  if (bit_cnt == LAST_BIT) begin
                     // Clear leftovers so out_bit idles low between slices.
                     shift_reg   <= '0;
                     bit_cnt     <= '0;
                     out_valid_q <= 1'b0;
                     if (page_idx == LAST_PAGE) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        page_idx <= '0;
                     end else begin
                        page_idx   <= page_idx + PAGE_BITS'(1);
                        in_ready_q <= 1'b1;
                        state      <= S_LOAD;
                     end
                  end else begin
                     shift_reg <= {fill_bit, shift_reg[WORD_LENGTH-1:1]};
                     bit_cnt   <= bit_cnt + BIT_BITS'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slice_unloader.sv
// Directed bench for slice_unloader: reset, bit order, protocol corner
// cases, mid-frame reset, a full frame, and a full frame under random
// output backpressure. Define SLICE_PARITY_EN to check the parity build.
module tb_slice_unloader;

`ifdef SLICE_PARITY_EN
   localparam int W = 26;
`else
   localparam int W = 25;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [5:0] page_idx;
   logic       busy;
   logic       done;

   int n_vec = 0;
   int n_err = 0;
   int in_xfers = 0;
   int out_xfers = 0;
   int base_in;
   int base_out;

   slice_unloader_if bus ();

   slice_unloader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus),
      .page_idx (page_idx),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Count handshake transfers on the active edge.
   always @(posedge clk) begin
      if (bus.in_valid && bus.in_ready)   in_xfers  <= in_xfers + 1;
      if (bus.out_valid && bus.out_ready) out_xfers <= out_xfers + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Load one slice and drain nbits of it, checking every bit against the
   // slice contents (bits 0..24) and its even parity (bit 25).
   // Entered and left at a falling edge.
   task automatic drain_page(input logic [24:0] data, input int exp_page,
                             input bit stall, input bit pulse_start, input int nbits);
      logic exp_bit;
      int   n;
      check("page_idx", 32'(page_idx), exp_page);
      bus.in_data  = data;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 1);
      @(negedge clk);
      // in_valid stays high and in_data changes: both must be ignored in SHIFT
      bus.in_data = ~data;
      check("in_ready_shift", 32'(bus.in_ready), 0);
      for (int k = 0; k < nbits; k++) begin
         exp_bit = (k < 25) ? data[k] : ^data;
         check("out_valid", 32'(bus.out_valid), 1);
         check("out_bit", 32'(bus.out_bit), 32'(exp_bit));
         if (stall) begin
            for (int s = 0; s < 4 && $urandom_range(0, 1) == 0; s++) begin
               bus.out_ready = 1'b0;
               @(negedge clk);
               check("stall_valid", 32'(bus.out_valid), 1);
               check("stall_bit", 32'(bus.out_bit), 32'(exp_bit));
            end
         end
         bus.out_ready = 1'b1;
         if (pulse_start) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      rst          = 1'b0;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_bit", 32'(bus.out_bit), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_page_idx", 32'(page_idx), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      // Frame A: bit order, protocol corners, then reset at page 10
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 32'(busy), 1);
      check("start_in_ready", 32'(bus.in_ready), 1);
      check("start_page_idx", 32'(page_idx), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("load_wait_out_valid", 32'(bus.out_valid), 0);
         check("load_wait_in_ready", 32'(bus.in_ready), 1);
      end
      // 25'h0000005 -> 1,0,1 then 22 zeros (then parity 0 if enabled)
      drain_page(25'h0000005, 0, 1'b0, 1'b0, W);
      check("gap_in_ready", 32'(bus.in_ready), 1);
      check("gap_out_valid", 32'(bus.out_valid), 0);
      // all ones: parity bit 1; start pulses during SHIFT ignored
      drain_page(25'h1FFFFFF, 1, 1'b0, 1'b1, W);
      check("start_ignored_busy", 32'(busy), 1);
      // two ones: parity bit 0
      drain_page(25'h0000003, 2, 1'b0, 1'b0, W);
      for (int p = 3; p < 10; p++) drain_page(25'(p), p, 1'b1, 1'b0, W);
      drain_page(25'h00ABCDE, 10, 1'b0, 1'b0, 3);
      bus.out_ready = 1'b0;
      check("pre_rst_page_idx", 32'(page_idx), 10);
      check("pre_rst_out_valid", 32'(bus.out_valid), 1);
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 0);
      check("mid_rst_out_bit", 32'(bus.out_bit), 0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_page_idx", 32'(page_idx), 0);
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_done", 32'(done), 0);

      // Frame B: full frame, data = page number, no stalls
      base_in  = in_xfers;
      base_out = out_xfers;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b_busy", 32'(busy), 1);
      for (int p = 0; p < 64; p++) drain_page(25'(p), p, 1'b0, 1'b0, W);
      check("b_done", 32'(done), 1);
      check("b_busy_fall", 32'(busy), 0);
      check("b_page_idx", 32'(page_idx), 0);
      check("b_in_xfers", 32'(in_xfers - base_in), 64);
      check("b_out_xfers", 32'(out_xfers - base_out), 64 * W);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("b_done_pulse", 32'(done), 0);
      check("b_idle_out_valid", 32'(bus.out_valid), 0);

      // Frame C: full frame under random output backpressure
      base_in  = in_xfers;
      base_out = out_xfers;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < 64; p++)
         drain_page(25'(p * 723) ^ 25'h15A5A5A, p, 1'b1, 1'b0, W);
      check("c_done", 32'(done), 1);
      check("c_busy_fall", 32'(busy), 0);
      check("c_in_xfers", 32'(in_xfers - base_in), 64);
      check("c_out_xfers", 32'(out_xfers - base_out), 64 * W);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("c_done_pulse", 32'(done), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
